// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/result bundle for bin_to_bcd_seq.
// master = requester (drives start/bin_in), slave = converter (drives status/result).
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  localparam int NDW = $clog2(DIGITS + 1);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [NDW-1:0]        ndigits;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ndigits
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ndigits
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// A start in IDLE latches bin_in; WIDTH shift cycles later the result register,
// the significant-digit count and a one-cycle done pulse are updated together.
// Optional feature macro: BCD_BLANK_EN -- leading (insignificant) digits are
// reported as 4'hF instead of 4'h0; digit 0 is never blanked.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic               clk,
  input  logic               reset,   // asynchronous, active low
  bin_to_bcd_seq_if.slave    bus
);

  localparam int NDW = $clog2(DIGITS + 1);
  localparam int CW  = $clog2(WIDTH + 1);

  // Value shown on bcd_out when nothing has been converted yet (encoding of zero).
`ifdef BCD_BLANK_EN
  localparam logic [4*DIGITS-1:0] BCD_ZERO = {{(DIGITS-1){4'hF}}, 4'h0};
`else
  localparam logic [4*DIGITS-1:0] BCD_ZERO = '0;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     shift_q;
  logic [4*DIGITS-1:0]  scratch_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [NDW-1:0]       ndig_q;

  // Combinational next values for one double-dabble step.
  logic [4*DIGITS-1:0]  scratch_adj;
  logic [4*DIGITS-1:0]  scratch_d;
  logic [4*DIGITS-1:0]  result_d;
  logic [NDW-1:0]       ndig_d;
  // The adjusted MSB of the top digit is shifted out and never used; with a
  // correctly sized DIGITS it is always zero.
  logic                 unused_top_bit;

  // Add-3 correction: every digit >= 5 gets +3 inside its own nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] dig;
      assign dig = scratch_q[4*gi +: 4];
      assign scratch_adj[4*gi +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
    end
  endgenerate

  // Shift {scratch, shift_reg} left by one: the MSB of the binary operand enters digit 0.
  assign scratch_d      = {scratch_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
  assign unused_top_bit = scratch_adj[4*DIGITS-1];

  // Significant-digit count of the post-shift scratch: highest nonzero digit + 1, minimum 1.
  always_comb begin
    ndig_d = NDW'(1);
    for (int k = 1; k < DIGITS; k++) begin
      if (scratch_d[4*k +: 4] != 4'd0) begin
        ndig_d = NDW'(k + 1);
      end
    end
  end

  // Result formatting: units digit passes straight through, upper digits are
  // either passed through or blanked when they lie above the significant range.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_out
      if (gi == 0) begin : g_units
        assign result_d[3:0] = scratch_d[3:0];
      end else begin : g_upper
`ifdef BCD_BLANK_EN
        assign result_d[4*gi +: 4] = (NDW'(gi) >= ndig_d) ? 4'hF : scratch_d[4*gi +: 4];
`else
        assign result_d[4*gi +: 4] = scratch_d[4*gi +: 4];
`endif
      end
    end
  endgenerate

  // Control FSM with registered busy/done/result; result only changes on the last shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= BCD_ZERO;
      ndig_q    <= NDW'(1);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q   <= bus.bin_in;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= result_d;
            ndig_q  <= ndig_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ndigits = ndig_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 32-bit/10-digit instance and an 8-bit/3-digit instance.
// Expected results come from a decimal model and are queued at start, checked at done.
module tb_bin_to_bcd_seq;

  localparam int WA = 32, DA = 10;
  localparam int WB = 8,  DB = 3;

  logic clk;
  logic reset;

  bin_to_bcd_seq_if #(.WIDTH(WA), .DIGITS(DA)) ifa ();
  bin_to_bcd_seq_if #(.WIDTH(WB), .DIGITS(DB)) ifb ();

  bin_to_bcd_seq #(.WIDTH(WA), .DIGITS(DA)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  bin_to_bcd_seq #(.WIDTH(WB), .DIGITS(DB)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [39:0] bcd;
    logic [7:0]  nd;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Decimal reference: digit k = (v / 10^k) % 10, significant count, optional blanking.
  function automatic exp_t model(input longint unsigned v, input int nd);
    exp_t            e;
    longint unsigned r;
    int              d;
    r     = v;
    e.bcd = '0;
    e.nd  = 8'd1;
    for (int k = 0; k < nd; k++) begin
      d = int'(r % 10);
      e.bcd[4*k +: 4] = 4'(d);
      if (d != 0) e.nd = 8'(k + 1);
      r = r / 10;
    end
`ifdef BCD_BLANK_EN
    for (int k = 1; k < nd; k++) begin
      if (k >= int'(e.nd)) e.bcd[4*k +: 4] = 4'hF;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor for instance A: compares each done against the scoreboard head.
  initial begin : mon_a
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.done === 1'b1) begin
        chk("a_done_single", prev, 0);
        chk("a_done_expected", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_bcd", ifa.bcd_out, e.bcd);
          chk("a_ndigits", ifa.ndigits, e.nd);
          chk("a_latency", run, WA);
        end
      end
      prev = ifa.done;
      run  = (ifa.busy === 1'b1) ? run + 1 : 0;
    end
  end

  // Output monitor for instance B.
  initial begin : mon_b
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.done === 1'b1) begin
        chk("b_done_single", prev, 0);
        chk("b_done_expected", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_bcd", ifb.bcd_out, e.bcd);
          chk("b_ndigits", ifb.ndigits, e.nd);
          chk("b_latency", run, WB);
        end
      end
      prev = ifb.done;
      run  = (ifb.busy === 1'b1) ? run + 1 : 0;
    end
  end

  // Raise start now, drop it one cycle later; queue the expectation if it should be accepted.
  task automatic go_a(input logic [WA-1:0] v, input bit accept);
    ifa.start  = 1'b1;
    ifa.bin_in = v;
    if (accept) qa.push_back(model(64'(v), DA));
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic go_b(input logic [WB-1:0] v);
    ifb.start  = 1'b1;
    ifb.bin_in = v;
    qb.push_back(model(64'(v), DB));
    @(negedge clk);
    ifb.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) seen = 1'b1;
    end
    chk("a_done_timeout", seen, 1);
  endtask

  task automatic wait_done_b(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ifb.done === 1'b1) seen = 1'b1;
    end
    chk("b_done_timeout", seen, 1);
  endtask

  initial begin : stim
    exp_t z;
    // DIGITS must cover ceil(WIDTH*log10(2)) decimal digits.
    if (DA < (WA * 30103 + 99999) / 100000 || DB < (WB * 30103 + 99999) / 100000) begin
      $display("FAIL config: DIGITS too small for WIDTH");
      $fatal(1);
    end

    ifa.start = 1'b0; ifa.bin_in = '0;
    ifb.start = 1'b0; ifb.bin_in = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    z = model(0, DA);
    chk("a_rst_busy", ifa.busy, 0);
    chk("a_rst_done", ifa.done, 0);
    chk("a_rst_bcd", ifa.bcd_out, z.bcd);
    chk("a_rst_ndigits", ifa.ndigits, 1);
    z = model(0, DB);
    chk("b_rst_bcd", ifb.bcd_out, z.bcd);
    chk("b_rst_ndigits", ifb.ndigits, 1);
    reset = 1'b1;

    // Basic conversions, including full-scale and zero
    @(negedge clk); go_a(32'd123456789, 1'b1); wait_done_a(40);
    @(negedge clk); go_a(32'hFFFF_FFFF, 1'b1); wait_done_a(40);
    @(negedge clk); go_a(32'd0, 1'b1);         wait_done_a(40);

    // Start while busy is ignored; then restart in the done cycle
    @(negedge clk); go_a(32'd20220421, 1'b1);
    repeat (4) @(negedge clk);
    go_a(32'd7, 1'b0);
    chk("a_busy_during_ignored_start", ifa.busy, 1);
    wait_done_a(40);
    go_a(32'd55555, 1'b1);
    wait_done_a(40);
    repeat (3) @(negedge clk);
    chk("a_idle_after_restart", ifa.busy, 0);

    // Reset mid-conversion aborts without a done pulse
    go_a(32'd123456789, 1'b0);
    repeat (8) @(negedge clk);
    chk("a_busy_before_abort", ifa.busy, 1);
    reset = 1'b0;
    #1;
    z = model(0, DA);
    chk("a_abort_busy", ifa.busy, 0);
    chk("a_abort_done", ifa.done, 0);
    chk("a_abort_bcd", ifa.bcd_out, z.bcd);
    chk("a_abort_ndigits", ifa.ndigits, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); go_a(32'd99, 1'b1); wait_done_a(40);

    // Narrow instance
    @(negedge clk); go_b(8'd255); wait_done_b(20);
    @(negedge clk); go_b(8'd100); wait_done_b(20);
    @(negedge clk); go_b(8'd9);   wait_done_b(20);

    repeat (5) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
